// File: rtl/tlp_xcvr_pkg.sv
// Shared TLP transceiver types: C2F ring pointer/offset aliases, checksum modes
// and the chunk-consumer FSM states.
package tlp_xcvr_pkg;

    localparam int C2F_PTR_NBITS     = 3;
    localparam int C2F_CHUNK_NQWORDS = 16;
    localparam int CS_MODE_NBITS     = 2;

    typedef logic [C2F_PTR_NBITS-1:0]             C2FChunkPtr;
    typedef logic [$clog2(C2F_CHUNK_NQWORDS)-1:0] C2FChunkOffset;

    typedef enum logic [CS_MODE_NBITS-1:0] {
        CS_SUM    = 2'd0,
        CS_XOR    = 2'd1,
        CS_ROTXOR = 2'd2,
        CS_RSVD   = 2'd3
    } CsMode;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        ACK   = 3'd3,
        GUARD = 3'd4
    } ConsumerState;

endpackage

// File: rtl/c2f_chunk_checksummer_cs_fold.sv
// Combinational checksum step: folds one data word into the running checksum.
// The reserved mode folds like a plain sum.
module cs_fold
    import tlp_xcvr_pkg::*;
#(
    parameter int CS_WIDTH = 64
) (
    input  logic [CS_WIDTH-1:0]      i_cs,
    input  logic [CS_WIDTH-1:0]      i_data,
    input  logic [CS_MODE_NBITS-1:0] i_mode,
    output logic [CS_WIDTH-1:0]      o_cs
);

    always_comb begin
        o_cs = i_cs + i_data;
        case (CsMode'(i_mode))
            CS_XOR:    o_cs = i_cs ^ i_data;
            CS_ROTXOR: o_cs = {i_cs[CS_WIDTH-2:0], i_cs[CS_WIDTH-1]} ^ i_data;
            default:   o_cs = i_cs + i_data;
        endcase
    end

endmodule

// File: rtl/c2f_chunk_checksummer.sv
// Drains C2F ring chunks in order, folds each qword into a running checksum and
// releases every chunk with a one-cycle dtAck.
module c2f_chunk_checksummer
    import tlp_xcvr_pkg::*;
#(
    parameter int  PTR_NBITS     = 3,
    parameter int  CHUNK_NQWORDS = 16,
    parameter int  RD_LATENCY    = 1,
    parameter int  CS_WIDTH      = 64,
    localparam int OFF_NBITS     = $clog2(CHUNK_NQWORDS)
) (
    input  logic                     sysClk,
    input  logic                     sysRst_n,
    input  logic [PTR_NBITS-1:0]     wrPtr,
    input  logic [PTR_NBITS-1:0]     rdPtr,
    output logic                     dtAck,
    output logic [OFF_NBITS-1:0]     rdOffset,
    input  logic [CS_WIDTH-1:0]      rdData,
    input  logic [CS_MODE_NBITS-1:0] csMode,
    input  logic                     csReset,
    input  logic [31:0]              countInit,
    output logic [CS_WIDTH-1:0]      csData,
    output logic                     csValid,
    output logic                     busy
);

    localparam logic [RD_LATENCY-1:0] VLD_LAST = RD_LATENCY'(1) << (RD_LATENCY - 1);

    ConsumerState          r_state;
    ConsumerState          w_state_nxt;
    logic [OFF_NBITS-1:0]  r_offset;
    logic [RD_LATENCY-1:0] r_vld;
    logic [CS_WIDTH-1:0]   r_cs;
    logic                  r_cs_valid;
    logic [31:0]           r_remaining;
    logic                  w_issue;
    logic                  w_land;
    logic                  w_drained;
    logic [CS_WIDTH-1:0]   w_cs_nxt;

    // The qword landing this cycle is the last one in flight once only the top bit remains.
    assign w_land    = r_vld[RD_LATENCY-1];
    assign w_drained = (r_vld & ~VLD_LAST) == '0;

    assign rdOffset = r_offset;
    assign busy     = (r_state != IDLE);
    assign csData   = r_cs;
    assign csValid  = r_cs_valid;

    always_ff @(posedge sysClk) begin
        if (!sysRst_n) begin
            r_state  <= IDLE;
            r_offset <= '0;
            r_vld    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_vld   <= (r_vld << 1) | RD_LATENCY'(w_issue);
            if (w_issue) begin
                r_offset <= r_offset + OFF_NBITS'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        dtAck       = 1'b0;
        case (r_state)
            IDLE: begin
                if (wrPtr != rdPtr) begin
                    w_state_nxt = READ;
                end
            end
            READ: begin
                w_issue = 1'b1;
                if (r_offset == OFF_NBITS'(CHUNK_NQWORDS - 1)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (w_drained) begin
                    w_state_nxt = ACK;
                end
            end
            ACK: begin
                dtAck       = 1'b1;
                w_state_nxt = GUARD;
            end
            // Lets the externally advanced rdPtr settle before IDLE tests for empty.
            GUARD:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    cs_fold #(
        .CS_WIDTH (CS_WIDTH)
    ) u_cs_fold (
        .i_cs   (r_cs),
        .i_data (rdData),
        .i_mode (csMode),
        .o_cs   (w_cs_nxt)
    );

    // csReset outranks a qword landing in the same cycle.
    always_ff @(posedge sysClk) begin
        if (!sysRst_n) begin
            r_cs        <= '0;
            r_cs_valid  <= 1'b0;
            r_remaining <= countInit;
        end else if (csReset) begin
            r_cs        <= '0;
            r_cs_valid  <= (countInit == 32'd0);
            r_remaining <= countInit;
        end else if (w_land && (r_remaining != 32'd0)) begin
            r_cs        <= w_cs_nxt;
            r_remaining <= r_remaining - 32'd1;
            if (r_remaining == 32'd1) begin
                r_cs_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_c2f_chunk_checksummer.sv
// Bench for c2f_chunk_checksummer: two instances (read latency 1 and 3) share one
// C2F RAM image and are checked against a queue-based checksum model.
`timescale 1ns/1ps
module tb_c2f_chunk_checksummer;

    localparam int PN = 4;
    localparam int N  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [PN-1:0] wrPtr;
    logic [1:0]    csMode;
    logic [31:0]   countInit;
    logic          csReset_v  [2];
    logic [PN-1:0] rdPtr_v    [2] = '{default: '0};
    logic          dtAck_v    [2];
    logic [3:0]    rdOffset_v [2];
    logic [63:0]   rdData_v   [2];
    logic [63:0]   csData_v   [2];
    logic          csValid_v  [2];
    logic          busy_v     [2];

    logic [63:0] mem [16][16];
    logic [63:0] pipe0;
    logic [63:0] pipe1 [3];
    logic [63:0] seq [$];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int rs_q  [2][$];
    int ack_q [2][$];
    int vrise [2];
    logic busy_d [2] = '{default: 1'b0};
    logic val_d  [2] = '{default: 1'b0};

    c2f_chunk_checksummer #(.PTR_NBITS(PN), .CHUNK_NQWORDS(N), .RD_LATENCY(1), .CS_WIDTH(64)) u_dut_l1 (
        .sysClk(clk), .sysRst_n(rst_n), .wrPtr(wrPtr), .rdPtr(rdPtr_v[0]), .dtAck(dtAck_v[0]),
        .rdOffset(rdOffset_v[0]), .rdData(rdData_v[0]), .csMode(csMode), .csReset(csReset_v[0]),
        .countInit(countInit), .csData(csData_v[0]), .csValid(csValid_v[0]), .busy(busy_v[0]));

    c2f_chunk_checksummer #(.PTR_NBITS(PN), .CHUNK_NQWORDS(N), .RD_LATENCY(3), .CS_WIDTH(64)) u_dut_l3 (
        .sysClk(clk), .sysRst_n(rst_n), .wrPtr(wrPtr), .rdPtr(rdPtr_v[1]), .dtAck(dtAck_v[1]),
        .rdOffset(rdOffset_v[1]), .rdData(rdData_v[1]), .csMode(csMode), .csReset(csReset_v[1]),
        .countInit(countInit), .csData(csData_v[1]), .csValid(csValid_v[1]), .busy(busy_v[1]));

    // External reader pointer and RAM with 1- and 3-cycle read latency.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (dtAck_v[i]) rdPtr_v[i] <= rdPtr_v[i] + 1'b1;
        end
        pipe0    <= mem[rdPtr_v[0]][rdOffset_v[0]];
        pipe1[0] <= mem[rdPtr_v[1]][rdOffset_v[1]];
        pipe1[1] <= pipe1[0];
        pipe1[2] <= pipe1[1];
    end
    assign rdData_v[0] = pipe0;
    assign rdData_v[1] = pipe1[2];

    // Event log: read starts, dtAck cycles, csValid rise.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (busy_v[i] && !busy_d[i]) rs_q[i].push_back(cyc);
            if (dtAck_v[i]) ack_q[i].push_back(cyc);
            if (csValid_v[i] && !val_d[i]) vrise[i] = cyc;
            busy_d[i] = busy_v[i];
            val_d[i]  = csValid_v[i];
        end
        cyc++;
    end

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [63:0] model(input logic [1:0] mode, input int first, input int cnt);
        logic [63:0] cs = 64'd0;
        for (int j = first; j < first + cnt && j < seq.size(); j++) begin
            case (mode)
                2'd1:    cs = cs ^ seq[j];
                2'd2:    cs = ((cs << 1) | (cs >> 63)) ^ seq[j];
                default: cs = cs + seq[j];
            endcase
        end
        return cs;
    endfunction

    task automatic restart(input int cnt, input logic [1:0] mode);
        countInit = cnt;
        csMode    = mode;
        csReset_v[0] = 1'b1;
        csReset_v[1] = 1'b1;
        @(negedge clk);
        csReset_v[0] = 1'b0;
        csReset_v[1] = 1'b0;
        seq.delete();
        for (int i = 0; i < 2; i++) begin
            rs_q[i].delete();
            ack_q[i].delete();
            vrise[i] = -1;
        end
    endtask

    // kind 0: 1,2,3..; kind 1: 0x8000000000000001; kind 2: random.
    task automatic load(input int nchunks, input int kind);
        logic [63:0] v;
        for (int c = 0; c < nchunks; c++) begin
            for (int k = 0; k < N; k++) begin
                case (kind)
                    0:       v = 64'(seq.size() + 1);
                    1:       v = 64'h8000_0000_0000_0001;
                    default: v = {$urandom, $urandom};
                endcase
                mem[(int'(wrPtr) + c) % 16][k] = v;
                seq.push_back(v);
            end
        end
        wrPtr = wrPtr + PN'(nchunks);
    endtask

    task automatic wait_done(input string name);
        bit ok = 1'b0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk);
            ok = !busy_v[0] && !busy_v[1] && rdPtr_v[0] == wrPtr && rdPtr_v[1] == wrPtr;
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_drain_timeout: rdPtr=%0d/%0d required %0d", name, rdPtr_v[0], rdPtr_v[1], wrPtr);
        end
    endtask

    task automatic wait_busy(input string name);
        bit ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = busy_v[0];
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_start_timeout: busy=0 required 1", name);
        end
    endtask

    task automatic check_result(input string name, input logic [63:0] exp_cs, input logic exp_val, input int exp_acks);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (csData_v[i] !== exp_cs) begin
                n_fail++;
                $display("FAIL %s_csData[L%0d]: got %h required %h", name, lat(i), csData_v[i], exp_cs);
            end
            n_cmp++;
            if (csValid_v[i] !== exp_val) begin
                n_fail++;
                $display("FAIL %s_csValid[L%0d]: got %b required %b", name, lat(i), csValid_v[i], exp_val);
            end
            n_cmp++;
            if (ack_q[i].size() != exp_acks) begin
                n_fail++;
                $display("FAIL %s_ackCount[L%0d]: got %0d required %0d", name, lat(i), ack_q[i].size(), exp_acks);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wrPtr = '0; csMode = 2'd0; countInit = 32'd16;
        csReset_v[0] = 1'b0; csReset_v[1] = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({busy_v[i], dtAck_v[i], csValid_v[i], rdOffset_v[i], csData_v[i]} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs[L%0d]: busy=%b dtAck=%b csValid=%b rdOffset=%0d csData=%h required all 0",
                         lat(i), busy_v[i], dtAck_v[i], csValid_v[i], rdOffset_v[i], csData_v[i]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sum_inc();
        logic [PN-1:0] st = rdPtr_v[0];
        restart(16, 2'd0);
        load(1, 0);
        wait_done("sum_inc");
        check_result("sum_inc", 64'd136, 1'b1, 1);
        for (int i = 0; i < 2; i++) begin
            int rs  = (rs_q[i].size() > 0) ? rs_q[i][0] : -1000;
            int ack = (ack_q[i].size() > 0) ? ack_q[i][0] : -1000;
            n_cmp++;
            if (vrise[i] != rs + 15 + lat(i) + 1 || vrise[i] != ack) begin
                n_fail++;
                $display("FAIL sum_inc_valid_time[L%0d]: rise=%0d required %0d (dtAck at %0d)", lat(i), vrise[i], rs + 16 + lat(i), ack);
            end
            n_cmp++;
            if (rdPtr_v[i] !== PN'(st + 1'b1)) begin
                n_fail++;
                $display("FAIL sum_inc_rdPtr[L%0d]: got %0d required %0d", lat(i), rdPtr_v[i], PN'(st + 1'b1));
            end
        end
    endtask

    task automatic test_xor_rot();
        restart(16, 2'd1);
        load(1, 0);
        wait_done("xor");
        check_result("xor", 64'h10, 1'b1, 1);
        restart(32, 2'd2);
        load(2, 1);
        wait_done("rotxor");
        check_result("rotxor", model(2'd2, 0, 32), 1'b1, 2);
    endtask

    task automatic test_random_modes();
        for (int r = 0; r < 3; r++) begin
            logic [1:0] m = 2'($urandom_range(0, 3));
            int cnt = $urandom_range(1, 32);
            restart(cnt, m);
            load(2, 2);
            wait_done("rand_mode");
            check_result("rand_mode", model(m, 0, cnt), 1'b1, 2);
        end
    endtask

    task automatic test_back_to_back();
        logic [PN-1:0] st = rdPtr_v[0];
        restart(128, 2'd0);
        load(8, 2);
        wait_done("ring8");
        check_result("ring8", model(2'd0, 0, 128), 1'b1, 8);
        for (int i = 0; i < 2; i++) begin
            for (int j = 1; j < ack_q[i].size(); j++) begin
                n_cmp++;
                if (ack_q[i][j] - ack_q[i][j-1] != N + lat(i) + 3) begin
                    n_fail++;
                    $display("FAIL ring8_spacing[L%0d][%0d]: got %0d required %0d", lat(i), j, ack_q[i][j] - ack_q[i][j-1], N + lat(i) + 3);
                end
            end
            n_cmp++;
            if (rdPtr_v[i] !== PN'(st + 4'd8)) begin
                n_fail++;
                $display("FAIL ring8_rdPtr[L%0d]: got %0d required %0d", lat(i), rdPtr_v[i], PN'(st + 4'd8));
            end
        end
    endtask

    task automatic test_count_exhaust();
        restart(20, 2'd0);
        load(2, 2);
        wait_done("count20");
        check_result("count20", model(2'd0, 0, 20), 1'b1, 2);
        for (int i = 0; i < 2; i++) begin
            int rs = (rs_q[i].size() > 1) ? rs_q[i][1] : -1000;
            n_cmp++;
            if (vrise[i] != rs + 3 + lat(i) + 1) begin
                n_fail++;
                $display("FAIL count20_valid_time[L%0d]: rise=%0d required %0d", lat(i), vrise[i], rs + 4 + lat(i));
            end
        end
    endtask

    task automatic test_cs_reset();
        restart(16, 2'd0);
        load(1, 2);
        wait_busy("csreset");
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) csReset_v[i] = (c == 4 + lat(i));
        end
        csReset_v[0] = 1'b0;
        csReset_v[1] = 1'b0;
        wait_done("csreset");
        check_result("csreset_mid", model(2'd0, 5, 11), 1'b0, 1);
        countInit = 32'd0;
        csReset_v[0] = 1'b1;
        csReset_v[1] = 1'b1;
        @(negedge clk);
        csReset_v[0] = 1'b0;
        csReset_v[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (csValid_v[i] !== 1'b1 || csData_v[i] !== 64'd0) begin
                n_fail++;
                $display("FAIL count0_valid[L%0d]: csValid=%b csData=%h required 1 and 0", lat(i), csValid_v[i], csData_v[i]);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        restart(16, 2'd0);
        load(1, 2);
        wait_busy("rstmid");
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({busy_v[i], dtAck_v[i], csValid_v[i], rdOffset_v[i], csData_v[i]} !== '0) begin
                n_fail++;
                $display("FAIL rstmid_outputs[L%0d]: busy=%b dtAck=%b csValid=%b rdOffset=%0d csData=%h required all 0",
                         lat(i), busy_v[i], dtAck_v[i], csValid_v[i], rdOffset_v[i], csData_v[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_done("rstmid");
        check_result("rstmid", model(2'd0, 0, 16), 1'b1, 1);
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (rs_q[i].size() != 2) begin
                n_fail++;
                $display("FAIL rstmid_reread[L%0d]: read starts=%0d required 2", lat(i), rs_q[i].size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sum_inc();
        test_xor_rot();
        test_random_modes();
        test_back_to_back();
        test_count_exhaust();
        test_cs_reset();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/c2f_chunk_checksummer.md
Name: c2f_chunk_checksummer

Overview:
Parametrised successor to example_consumer. It drains CPU->FPGA burst-written chunks from the single-clock C2F RAM, one chunk at a time, in ring order. It folds each 64-bit qword into a running checksum using a runtime-selectable algorithm. It raises csValid once a programmed qword count has been absorbed and releases each chunk back to the writer via a one-cycle dtAck.

Parameters:
PTR_NBITS, 3, width of the chunk ring pointers (ring holds 2^PTR_NBITS chunks)
CHUNK_NQWORDS, 16, qwords per chunk (C2F_CHUNKSIZE/8); must be a power of two, >= 2
RD_LATENCY, 1, RAM read latency in cycles from rdOffset to rdData (1..4)
CS_WIDTH, 64, checksum/data width in bits

Ports:
sysClk  in  1  system clock; all logic on rising edge
sysRst_n  in  1  synchronous active-low reset
wrPtr  in  PTR_NBITS  writer's next-chunk pointer
rdPtr  in  PTR_NBITS  reader pointer, held externally; increments on the edge after dtAck
dtAck  out  1  one-cycle pulse: current chunk fully read, advance rdPtr
rdOffset  out  log2(CHUNK_NQWORDS)  qword offset within chunk rdPtr
rdData  in  CS_WIDTH  RAM read data, valid RD_LATENCY cycles after rdOffset
csMode  in  2  00 sum mod 2^CS_WIDTH, 01 XOR, 10 rotl1-XOR (cs=rotl(cs,1)^d), 11 treated as 00
csReset  in  1  clear checksum, reload count from countInit
countInit  in  32  number of qwords to fold before csValid
csData  out  CS_WIDTH  running checksum
csValid  out  1  high when count exhausted; held until csReset/reset
busy  out  1  high while FSM not in IDLE

Behaviour:
- Reset (sysRst_n=0 at an edge): FSM=IDLE; dtAck=0; rdOffset=0; csData=0; csValid=0; busy=0; remaining-count loaded from countInit; read pipeline valid bits cleared. Reset mid-chunk abandons the chunk without dtAck.
- FSM IDLE: if wrPtr != rdPtr go READ (offset 0 presented next cycle), else stay.
- FSM READ: rdOffset steps 0..CHUNK_NQWORDS-1, one per cycle, no gaps. Each issued offset pushes a valid bit into a RD_LATENCY-deep shift pipeline. After the last offset go DRAIN.
- FSM DRAIN: wait until the pipeline is empty (RD_LATENCY cycles), then go ACK.
- FSM ACK: dtAck=1 for exactly one cycle, then go GUARD.
- FSM GUARD: one cycle, so the external rdPtr update is visible before the empty test; then go IDLE.
- Chunk throughput: CHUNK_NQWORDS+RD_LATENCY+3 cycles. csMode is sampled per qword and may change between chunks.
- Fold rule, on a pipeline-valid cycle with remaining>0 and csReset=0:
  - csData updates per csMode on the next edge.
  - remaining decrements.
  - When remaining goes 1->0, csValid rises on that same edge.
- remaining==0: further qwords are still read and acked but not folded, so the ring never stalls.
- csReset=1: next edge csData=0, csValid=0, remaining=countInit. A qword landing in the same cycle is discarded (csReset wins). If countInit=0, csValid=1 on the edge after csReset.
- Ring pointers wrap modulo 2^PTR_NBITS. wrPtr==rdPtr always means empty; the writer must not overrun.
- Sum arithmetic truncates to CS_WIDTH. Rotation is within CS_WIDTH.

Decomposition:
- tlp_xcvr_pkg gains:
  - CsMode enum (CS_SUM, CS_XOR, CS_ROTXOR, CS_RSVD)
  - ConsumerState enum (IDLE, READ, DRAIN, ACK, GUARD)
  - CS_MODE_NBITS constant
- The existing C2FChunkPtr/C2FChunkOffset typedefs remain the default-width aliases.
- One sub-module, cs_fold: combinational next-checksum from (csData, rdData, csMode). Shared with the F2C checker later.

Test Plan:
- countInit=16, csMode=00, one chunk of qwords 1..16 -> csData=136, csValid rises one edge after the 16th qword lands, exactly one dtAck, rdPtr 0->1.
- Same data, csMode=01 -> csData=0x10. csMode=10, qwords all 0x8000000000000001 x2 -> csData=0x8000000000000002 ^ ... (check against reference model), csValid after countInit.
- 8 chunks preloaded (wrPtr wraps to 0 with PTR_NBITS=4 so wrPtr=8), countInit=128 -> 8 dtAck pulses spaced CHUNK_NQWORDS+RD_LATENCY+3 cycles apart, rdPtr=8, csValid=1, csData equals model sum of SEQ64[0..127].
- countInit=20, two chunks -> csValid after qword 20, folding stops, csData=sum of the first 20 qwords, second chunk still acked.
- csReset pulsed in the cycle qword 5 lands -> that qword excluded, csData restarts at 0, count reloaded; countInit=0 with csReset -> csValid=1 the next cycle.
- sysRst_n low mid-READ for 2 cycles -> all outputs at reset values, no dtAck; chunk reread from offset 0 afterward; RD_LATENCY=3 rerun of scenario 1 gives the same csData.
